// File: rtl/byte_serial_addsub_ctrl.sv
// byte_serial_addsub_ctrl: byte-serial W-bit add/subtract controller reusing one 8-bit adder
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   start_valid/start_ready     request handshake; op (0 add, 1 sub), a, b captured on accept
//   res_valid/res_ready         result handshake; result, cout, ovf valid while res_valid
//   busy                        high while an operation is in RUN or DONE
module eight_bit_adder_sub (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);
  assign {cout, sum} = 9'(a) + 9'(b) + 9'(cin);
endmodule

module byte_serial_addsub_ctrl #(
  parameter int NBYTES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_valid,
  output logic                start_ready,
  input  logic                op,
  input  logic [8*NBYTES-1:0] a,
  input  logic [8*NBYTES-1:0] b,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [8*NBYTES-1:0] result,
  output logic                cout,
  output logic                ovf,
  output logic                busy
);
  localparam int W  = 8 * NBYTES;
  localparam int IW = $clog2(NBYTES);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t st, ns;
  logic [W-1:0] a_reg, b_reg;
  logic op_reg, carry, co, last;
  logic [IW-1:0] idx;
  logic [7:0] a_byte, b_byte, sum;
  // subtraction is a + ~b + 1: the inversion is applied per byte and the +1 enters via the carry seeded with op
  assign a_byte = a_reg[{idx, 3'b000} +: 8];
  assign b_byte = b_reg[{idx, 3'b000} +: 8] ^ {8{op_reg}};
  assign last   = idx == IW'(NBYTES - 1);
  eight_bit_adder_sub u_add (
    .a    (a_byte),
    .b    (b_byte),
    .cin  (carry),
    .sum  (sum),
    .cout (co)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) st <= IDLE;
    else        st <= ns;
  always_comb
    ns = st == IDLE ? (start_valid ? RUN : IDLE) :
         st == RUN  ? (last ? DONE : RUN) :
                      (res_ready ? IDLE : DONE);
  always_comb begin
    start_ready = st == IDLE;
    res_valid   = st == DONE;
    busy        = st != IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      a_reg  <= '0;
      b_reg  <= '0;
      op_reg <= 1'b0;
      carry  <= 1'b0;
      idx    <= '0;
      result <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
    end else if (st == IDLE && start_valid) begin
      a_reg  <= a;
      b_reg  <= b;
      op_reg <= op;
      carry  <= op;
      idx    <= '0;
    end else if (st == RUN) begin
      result[{idx, 3'b000} +: 8] <= sum;
      carry <= co;
      // the index stops at the last byte instead of wrapping
      if (!last) idx <= idx + 1'b1;
      if (last) begin
        cout <= co;
        // the top byte's sum bit is the final result sign
        ovf  <= (a_reg[W-1] == (b_reg[W-1] ^ op_reg)) && (sum[7] != a_reg[W-1]);
      end
    end
endmodule

// File: doc/byte_serial_addsub_ctrl.md
BYTE_SERIAL_ADDSUB_CTRL -- requirements
Module: byte_serial_addsub_ctrl

Interface
REQ-001 The block SHALL have one parameter: NBYTES, default 4, operand width in bytes (legal 2..8); W = 8*NBYTES.
REQ-002 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-003 The block SHALL provide these ports, named and sized as listed:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start_valid  input  1  request present
- start_ready  output  1  controller can accept a request
- op  input  1  0 = add, 1 = subtract (a - b)
- a  input  W  operand A
- b  input  W  operand B
- res_valid  output  1  result present
- res_ready  input  1  consumer accepts result
- result  output  W  sum/difference, modulo 2^W
- cout  output  1  final carry-out; for subtract, 1 = no borrow
- ovf  output  1  two's-complement signed overflow
- busy  output  1  high in RUN or DONE

Function
REQ-004 The block SHALL contain exactly one 8-bit add/sub datapath (eight_bit_adder_sub: a[7:0], b[7:0], cin, sum[7:0], cout) and SHALL reuse it for every byte; no wider adder is permitted.
REQ-005 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-006 IDLE SHALL assert start_ready = 1 and res_valid = 0.
REQ-007 A handshake (start_valid && start_ready) SHALL capture a, b and op into internal registers, load the carry register with op, clear the byte index, and move to RUN.
REQ-008 RUN SHALL process byte k = 0..NBYTES-1, one byte per cycle, in ascending order, driving the adder as follows:
- a: a_reg[8k+7:8k]
- b: b_reg[8k+7:8k] XOR {8{op_reg}}
- cin: carry register
REQ-009 At the end of each RUN cycle the block SHALL store the adder sum into result bits [8k+7:8k] and the adder cout into the carry register.
REQ-010 After byte NBYTES-1 the block SHALL enter DONE, with cout = final carry and ovf = (a_reg[W-1] == b_eff[W-1]) && (result[W-1] != a_reg[W-1]), where b_eff is b_reg XOR {W{op_reg}}.
REQ-011 Latency SHALL be exact: accept at rising edge N gives res_valid = 1 from edge N+NBYTES (4 cycles at default).
REQ-012 DONE SHALL hold res_valid = 1 with result, cout and ovf stable until res_ready = 1, then return to IDLE on that edge.
REQ-013 start_ready SHALL be 0 in RUN and DONE, and start_valid, a, b and op SHALL be ignored there; there is no request overlap.
REQ-014 When res_ready and start_valid are both 1 in DONE, the block SHALL return to IDLE and accept the new request no earlier than the following edge.
REQ-015 result, cout and ovf SHALL hold their last values after leaving DONE until the next request's RUN overwrites them; they are valid only while res_valid = 1.
REQ-016 res_ready SHALL be ignored outside DONE.
REQ-017 The byte index SHALL be clog2(NBYTES) bits wide and SHALL NOT wrap within an operation.
REQ-018 All arithmetic SHALL be modulo 2^W, with no saturation.

Reset
REQ-019 rst_n = 0 SHALL immediately, without waiting for clk, force IDLE and clear all internal registers and outputs, including mid-RUN and in DONE:
- start_ready = 1
- res_valid = 0, busy = 0
- result = 0, cout = 0, ovf = 0
REQ-020 Any operation in progress when reset asserts SHALL be discarded, and the block SHALL produce no res_valid for it after reset deasserts.
REQ-021 The first request after reset deassertion SHALL be accepted on the first rising edge with start_valid = 1.

Verification
REQ-022 The bench SHALL cover these directed scenarios (NBYTES = 4):
- add 0x000000FF + 0x00000001 -> result 0x00000100, cout 0, ovf 0, res_valid exactly 4 cycles after accept.
- add 0xFFFFFFFF + 0x00000001 -> result 0x00000000, cout 1, ovf 0 (carry ripples through all 4 bytes).
- sub 0x00000000 - 0x00000001 -> result 0xFFFFFFFF, cout 0 (borrow), ovf 0; sub 0x80000000 - 0x00000001 -> 0x7FFFFFFF, cout 1, ovf 1.
- add 0x7FFFFFFF + 0x00000001 -> result 0x80000000, cout 0, ovf 1.
- Hold res_ready = 0 for 3 cycles in DONE while start_valid = 1 with new operands -> res_valid, result, cout and ovf stable, start_ready 0; after res_ready = 1 the new request is accepted one cycle later and completes correctly.
- Assert rst_n = 0 mid-cycle during RUN byte 2 -> outputs cleared before the next clk edge, FSM in IDLE, start_ready = 1, no stale res_valid after release.
